// File: rtl/prog_pkg.sv
// rtl/prog_pkg.sv - shared state type and default sizing for the program sequencer
package prog_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int PROG_D          = 12;
   localparam int PROG_LUT_W      = 5;
   localparam int PROG_START_ADDR = 0;
   localparam int PROG_CNT_W      = 16;

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch target table: one synchronous write port, one combinational read port
module branch_lut #(
   parameter int D     = 12,
   parameter int LUT_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we_i,
   input  logic [LUT_W-1:0] waddr_i,
   input  logic [D-1:0]     wdata_i,
   input  logic [LUT_W-1:0] raddr_i,
   output logic [D-1:0]     rdata_o
);

   logic [D-1:0] mem_q [2**LUT_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2**LUT_W; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Reads the stored value, so a same-cycle write to this index is not yet visible.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_ctr_seq.sv
// rtl/prog_ctr_seq.sv - program counter sequencer with start/done handshake and LUT branch redirect
module prog_ctr_seq
   import prog_pkg::*;
#(
   parameter int D          = PROG_D,
   parameter int LUT_W      = PROG_LUT_W,
   parameter int START_ADDR = PROG_START_ADDR,
   parameter int CNT_W      = PROG_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stall,
   input  logic             halt_i,
   input  logic             taken_i,
   input  logic [LUT_W-1:0] target_idx,
   input  logic             lut_we,
   input  logic [LUT_W-1:0] lut_waddr,
   input  logic [D-1:0]     lut_wdata,
   output logic [D-1:0]     prog_ctr,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [D-1:0] START_PC = D'(START_ADDR);
   localparam logic [D-1:0] PC_MAX   = '1;

   seq_state_t       state_q, state_d;
   logic [D-1:0]     pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovr_q, ovr_d;
   logic [D-1:0]     lut_rdata;

   branch_lut #(
      .D     (D),
      .LUT_W (LUT_W)
   ) u_lut (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (lut_we),
      .waddr_i (lut_waddr),
      .wdata_i (lut_wdata),
      .raddr_i (target_idx),
      .rdata_o (lut_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      case (state_q)
         IDLE: begin
            pc_d = START_PC;
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               ovr_d   = 1'b0;
            end
         end
         RUN: begin
            // Counter saturates rather than wrapping so long runs still read as "long".
            if (!(&cnt_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (stall) begin
               pc_d = pc_q;
            end else if (halt_i) begin
               state_d = DONE;
            end else if (taken_i) begin
               pc_d = lut_rdata;
            end else if (pc_q == PC_MAX) begin
               state_d = DONE;
               ovr_d   = 1'b1;
            end else begin
               pc_d = pc_q + D'(1);
            end
         end
         DONE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = START_PC;
               cnt_d   = '0;
               ovr_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = START_PC;
         end
      endcase
   end

   assign prog_ctr    = pc_q;
   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign overrun     = ovr_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// tb/tb_prog_ctr_seq.sv - directed table-driven bench for prog_ctr_seq (D=12 and D=4 instances)
module tb_prog_ctr_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        a_start, a_stall, a_halt, a_taken, a_we;
   logic [4:0]  a_tidx, a_waddr;
   logic [11:0] a_wdata, a_pc;
   logic        a_busy, a_done, a_ovr;
   logic [15:0] a_cnt;

   logic        b_start, b_stall, b_halt, b_taken, b_we;
   logic [4:0]  b_tidx, b_waddr;
   logic [3:0]  b_wdata, b_pc;
   logic        b_busy, b_done, b_ovr;
   logic [3:0]  b_cnt;

   prog_ctr_seq u_dut_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .stall(a_stall),
      .halt_i(a_halt), .taken_i(a_taken), .target_idx(a_tidx),
      .lut_we(a_we), .lut_waddr(a_waddr), .lut_wdata(a_wdata),
      .prog_ctr(a_pc), .busy(a_busy), .done(a_done), .overrun(a_ovr),
      .cycle_count(a_cnt)
   );

   prog_ctr_seq #(.D(4), .LUT_W(5), .START_ADDR(0), .CNT_W(4)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .stall(b_stall),
      .halt_i(b_halt), .taken_i(b_taken), .target_idx(b_tidx),
      .lut_we(b_we), .lut_waddr(b_waddr), .lut_wdata(b_wdata),
      .prog_ctr(b_pc), .busy(b_busy), .done(b_done), .overrun(b_ovr),
      .cycle_count(b_cnt)
   );

   typedef struct {
      logic        start, stall, halt, taken;
      logic [4:0]  tidx;
      logic        we;
      logic [4:0]  waddr;
      logic [11:0] wdata;
      logic [11:0] e_pc;
      logic        e_busy, e_done, e_ovr;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vq[$];
   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic add(input logic st, input logic sl, input logic h, input logic tk,
                      input logic [4:0] ti, input logic we, input logic [4:0] wa,
                      input logic [11:0] wd, input logic [11:0] pc, input logic b,
                      input logic dn, input logic ov, input logic [15:0] c);
      vec_t v;
      v.start = st; v.stall = sl; v.halt = h; v.taken = tk; v.tidx = ti;
      v.we = we; v.waddr = wa; v.wdata = wd;
      v.e_pc = pc; v.e_busy = b; v.e_done = dn; v.e_ovr = ov; v.e_cnt = c;
      vq.push_back(v);
   endtask

   task automatic plain(input logic [11:0] pc, input logic [15:0] c);
      add(0, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, pc, 1, 0, 0, c);
   endtask

   task automatic a_idle_inputs();
      a_start = 0; a_stall = 0; a_halt = 0; a_taken = 0; a_we = 0;
      a_tidx = '0; a_waddr = '0; a_wdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [11:0] pc, input logic b,
                        input logic dn, input logic ov, input logic [15:0] c);
      chk({tag, "_pc"},   {20'd0, a_pc},  {20'd0, pc});
      chk({tag, "_busy"}, {31'd0, a_busy}, {31'd0, b});
      chk({tag, "_done"}, {31'd0, a_done}, {31'd0, dn});
      chk({tag, "_ovr"},  {31'd0, a_ovr},  {31'd0, ov});
      chk({tag, "_cnt"},  {16'd0, a_cnt},  {16'd0, c});
   endtask

   task automatic chk_b(input string tag, input logic [3:0] pc, input logic b,
                        input logic dn, input logic ov, input logic [3:0] c);
      chk({tag, "_pc"},   {28'd0, b_pc},  {28'd0, pc});
      chk({tag, "_busy"}, {31'd0, b_busy}, {31'd0, b});
      chk({tag, "_done"}, {31'd0, b_done}, {31'd0, dn});
      chk({tag, "_ovr"},  {31'd0, b_ovr},  {31'd0, ov});
      chk({tag, "_cnt"},  {28'd0, b_cnt},  {28'd0, c});
   endtask

   initial begin
      // Run 1: plain fetch then halt at 5.
      add(1, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, 12'h000, 1, 0, 0, 16'd0);
      for (int k = 1; k <= 5; k++) plain(12'(k), 16'(k));
      add(0, 0, 1, 0, 5'd0, 0, 5'd0, 12'h0, 12'h005, 0, 1, 0, 16'd6);
      // Run 2: redirects, start ignored in RUN, same-cycle LUT write, halt beats taken.
      add(1, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, 12'h000, 1, 0, 0, 16'd0);
      plain(12'h001, 16'd1);
      plain(12'h002, 16'd2);
      add(0, 0, 0, 1, 5'd3, 0, 5'd0, 12'h0, 12'h040, 1, 0, 0, 16'd3);
      plain(12'h041, 16'd4);
      add(1, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, 12'h042, 1, 0, 0, 16'd5);
      add(0, 0, 0, 1, 5'd2, 1, 5'd2, 12'h100, 12'h010, 1, 0, 0, 16'd6);
      add(0, 0, 0, 1, 5'd2, 0, 5'd0, 12'h0, 12'h100, 1, 0, 0, 16'd7);
      add(0, 0, 1, 1, 5'd3, 0, 5'd0, 12'h0, 12'h100, 0, 1, 0, 16'd8);
      add(0, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, 12'h100, 0, 1, 0, 16'd8);
      // Run 3: stall with pending halt at 7.
      add(1, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, 12'h000, 1, 0, 0, 16'd0);
      for (int k = 1; k <= 7; k++) plain(12'(k), 16'(k));
      for (int k = 8; k <= 10; k++) add(0, 1, 1, 0, 5'd0, 0, 5'd0, 12'h0, 12'h007, 1, 0, 0, 16'(k));
      add(0, 0, 1, 0, 5'd0, 0, 5'd0, 12'h0, 12'h007, 0, 1, 0, 16'd11);
      add(0, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, 12'h007, 0, 1, 0, 16'd11);
      // Run 4: walk to 9 for the mid-run reset.
      add(1, 0, 0, 0, 5'd0, 0, 5'd0, 12'h0, 12'h000, 1, 0, 0, 16'd0);
      for (int k = 1; k <= 9; k++) plain(12'(k), 16'(k));

      reset_n = 1'b0;
      a_idle_inputs();
      b_start = 0; b_stall = 0; b_halt = 0; b_taken = 0; b_we = 0;
      b_tidx = '0; b_waddr = '0; b_wdata = '0;
      #12;
      chk_a("reset", 12'h000, 0, 0, 0, 16'd0);
      tick();
      reset_n = 1'b1;

      // Preload LUT while IDLE; sequencer must stay put.
      a_we = 1; a_waddr = 5'd3; a_wdata = 12'h040;
      tick();
      a_waddr = 5'd2; a_wdata = 12'h010;
      tick();
      a_idle_inputs();
      chk_a("idle", 12'h000, 0, 0, 0, 16'd0);

      for (int i = 0; i < vq.size(); i++) begin
         a_start = vq[i].start; a_stall = vq[i].stall; a_halt = vq[i].halt;
         a_taken = vq[i].taken; a_tidx = vq[i].tidx; a_we = vq[i].we;
         a_waddr = vq[i].waddr; a_wdata = vq[i].wdata;
         tick();
         chk_a($sformatf("row%0d", i), vq[i].e_pc, vq[i].e_busy, vq[i].e_done,
               vq[i].e_ovr, vq[i].e_cnt);
      end
      a_idle_inputs();

      // Asynchronous reset between edges with start held high.
      #3;
      a_start = 1;
      reset_n = 1'b0;
      #1;
      chk_a("async_rst", 12'h000, 0, 0, 0, 16'd0);
      tick();
      tick();
      chk_a("rst_hold", 12'h000, 0, 0, 0, 16'd0);
      a_start = 0;
      reset_n = 1'b1;
      a_start = 1;
      tick();
      a_start = 0;
      chk_a("post_rst_start", 12'h000, 1, 0, 0, 16'd0);
      a_taken = 1; a_tidx = 5'd3;
      tick();
      a_idle_inputs();
      chk_a("lut_cleared", 12'h000, 1, 0, 0, 16'd1);
      tick();
      chk_a("post_rst_fetch", 12'h001, 1, 0, 0, 16'd2);

      // D=4, CNT_W=4 instance: run off the end of ROM.
      b_start = 1;
      tick();
      b_start = 0;
      chk_b("b_start", 4'd0, 1, 0, 0, 4'd0);
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk({"b_walk_pc"}, {28'd0, b_pc}, 32'(k));
      end
      chk_b("b_at_end", 4'd15, 1, 0, 0, 4'd15);
      tick();
      chk_b("b_overrun", 4'd15, 0, 1, 1, 4'd15);
      tick();
      chk_b("b_hold", 4'd15, 0, 1, 1, 4'd15);
      b_start = 1;
      tick();
      b_start = 0;
      chk_b("b_restart", 4'd0, 1, 0, 0, 4'd0);
      tick();
      chk_b("b_restart_fetch", 4'd1, 1, 0, 0, 4'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prog_ctr_seq.md
Name: prog_ctr_seq

Overview:
- Program sequencer that owns and drives prog_ctr into the 9-bit instruction ROM.
- Provides the start/done handshake for a program run and sequential fetch.
- Redirects branches through a writable target lookup table, because a 9-bit instruction cannot hold a D-bit address.
- Sits between the top-level testbench/start logic and the ROM/control decode path.

Parameters:
D, 12, prog_ctr width; ROM depth is 2**D
LUT_W, 5, width of branch target index; LUT holds 2**LUT_W entries of D bits
START_ADDR, 0, prog_ctr value loaded on each start
CNT_W, 16, width of the cycle counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a run; honoured only in IDLE or DONE
stall  input  1  hold prog_ctr this cycle (RUN only)
halt_i  input  1  decoded halt from control for the current mach_code
taken_i  input  1  decoded taken branch for the current mach_code
target_idx  input  LUT_W  LUT index for the redirect
lut_we  input  1  LUT write enable
lut_waddr  input  LUT_W  LUT write index
lut_wdata  input  D  LUT write data (absolute address)
prog_ctr  output  D  ROM address
busy  output  1  high in RUN
done  output  1  high in DONE
overrun  output  1  run ended by PC running off the end of ROM
cycle_count  output  CNT_W  RUN cycles of the current/last run

Behaviour:
- Clock, reset and LUT contents:
  - One clock. reset is asynchronous and active-low (reset_n).
  - On reset: state=IDLE, prog_ctr=START_ADDR, busy=0, done=0, overrun=0, cycle_count=0, all LUT entries=0.
  - Reset asserted mid-run aborts immediately to these values.
- ROM and decode timing:
  - The ROM read is combinational, so halt_i/taken_i describe the instruction at the current prog_ctr in the same cycle.
  - prog_ctr changes only on a clock edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - prog_ctr held at START_ADDR.
  - start=1 -> RUN next edge: prog_ctr=START_ADDR, cycle_count=0, overrun=0.
- RUN (busy=1):
  - cycle_count increments every cycle, including stall cycles, and saturates at all-ones.
  - Next-PC priority at each edge:
    1. stall=1 -> prog_ctr holds; halt_i and taken_i are ignored.
    2. halt_i=1 -> DONE; prog_ctr holds at the halt address.
    3. taken_i=1 -> prog_ctr = LUT[target_idx].
    4. prog_ctr = 2**D-1 -> DONE, overrun=1, prog_ctr holds.
    5. Otherwise prog_ctr+1.
  - halt_i and taken_i both high: halt wins.
  - start in RUN is ignored.
- DONE:
  - done=1, busy=0; prog_ctr, cycle_count and overrun are held.
  - start=1 -> RUN restart exactly as from IDLE; done drops at that edge.
- LUT:
  - Synchronous write, allowed in any state.
  - The read is combinational from stored contents. A same-cycle write and redirect to the same index uses the old value; the new value is visible the next cycle.
- Arithmetic: prog_ctr is unsigned D-bit; a redirect to any value is legal. There is no silent wrap; the end of ROM is handled by rule 4 above.

Decomposition:
- Shared package prog_pkg:
  - typedef enum logic[1:0] {IDLE, RUN, DONE} seq_state_t.
  - Constants for D, LUT_W and START_ADDR defaults.
- One natural sub-module: branch_lut (2**LUT_W x D register array with one write port and one combinational read port), instantiated inside prog_ctr_seq.

Test Plan:
- Reset, then start pulse, no halt for 5 cycles -> prog_ctr 0,1,2,3,4,5; busy=1; cycle_count=5; done=0.
- Write LUT[3]=12'h040; in RUN at prog_ctr=2 assert taken_i with target_idx=3 -> next prog_ctr=0x040, then 0x041.
- stall=1 for 3 cycles with halt_i=1 at prog_ctr=7 -> prog_ctr holds at 7 and cycle_count still increments; release stall with halt_i still high -> DONE, done=1, prog_ctr=7.
- Same-cycle lut_we to index 2 (new value 0x100, old 0x010) while taken_i targets index 2 -> prog_ctr=0x010; the next redirect to index 2 -> 0x100.
- D=4 instance running with no halt -> reaches 15, then DONE with overrun=1, prog_ctr=15; start again -> prog_ctr=0, overrun=0, done=0.
- Drive reset_n low mid-run at prog_ctr=9 asynchronously (between edges) -> outputs reach reset values immediately; the LUT reads 0; start is ignored while reset_n is low.
